alu_stim_driver: RTL and testbench
==================================

// Module: alu_stim_driver
// PURPOSE
//  Synthesizable initiator that drives the ALU pin interface (rst, cin, red_op_A/B,
//  bypass_A/B, direction, serial_in, opcode, A, B) and collects its results (out, leds).
//  Accepts one ALU request over a valid/ready port, applies it to the ALU pins, waits a
//  fixed ALU latency, then captures out/leds and returns them over a valid/ready port.
//  Also sequences the ALU reset after system reset. Sits between a host/sequencer and the ALU.
// PARAMETERS
//  ALU_LATENCY     1   ALU clock edges from pins-applied to out/leds valid; legal 1..15
//  ALU_RST_CYCLES  4   cycles alu_rst is held high in INIT; legal 1..255
//  CNT_W           16  width of txn_count
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   asynchronous reset, active high
//  reinit         in   1   pulse: re-run ALU reset sequence (sampled in IDLE only)
//  req_valid      in   1   request valid
//  req_ready      out  1   request accepted when req_valid & req_ready
//  req_A, req_B   in   3   signed operands
//  req_opcode     in   3   ALU opcode
//  req_flags      in   7   {cin,red_op_A,red_op_B,bypass_A,bypass_B,direction,serial_in}
//  alu_rst        out  1   ALU reset
//  alu_A, alu_B   out  3   signed operands to ALU
//  alu_opcode     out  3   opcode to ALU
//  alu_flags      out  7   flags to ALU, same bit order as req_flags
//  alu_out        in   6   ALU result
//  alu_leds       in   16  ALU leds
//  rsp_valid      out  1   response valid
//  rsp_ready      in   1   response consumed when rsp_valid & rsp_ready
//  rsp_out        out  6   captured alu_out
//  rsp_leds       out  16  captured alu_leds
//  rsp_opcode     out  3   opcode of the transaction that produced the response
//  txn_count      out  CNT_W  completed transactions (rsp handshakes); wraps to 0
// BEHAVIOUR
//  Reset (async, immediate): state=INIT, alu_rst=1, init counter=0, req_ready=0,
//   rsp_valid=0, rsp_out/rsp_leds/rsp_opcode=0, alu_A/B/opcode/flags=0, txn_count=0.
//  States: INIT, IDLE, WAIT, RESP. One transaction outstanding at most.
//  INIT: alu_rst=1, req_ready=0; counter increments each edge after rst falls; alu_rst falls
//   and state->IDLE on the edge where counter reaches ALU_RST_CYCLES-1 (alu_rst high
//   exactly ALU_RST_CYCLES cycles after rst deasserts).
//  IDLE: req_ready=1 (combinational from state). reinit=1 -> INIT (counter cleared, alu_rst=1
//   next cycle); reinit wins over a simultaneous req_valid, which is then not accepted.
//   Else req_valid -> at accept edge N: alu_* pins <= req_*, wait counter <= ALU_LATENCY, ->WAIT.
//  WAIT: req_ready=0; counter decrements each edge; at edge N+ALU_LATENCY+1 (counter==0):
//   rsp_out<=alu_out, rsp_leds<=alu_leds, rsp_opcode<=alu_opcode, rsp_valid<=1, ->RESP.
//   Accept-to-rsp_valid latency = ALU_LATENCY+1 cycles.
//  alu_* operand/flag pins held stable from accept until next accept (not cleared after capture).
//  RESP: rsp_valid=1, rsp_* stable until handshake; rsp_ready may be held high early.
//   On handshake: rsp_valid<=0, txn_count<=txn_count+1 (wraps 2^CNT_W-1 -> 0), ->IDLE.
//   Earliest next accept is the cycle after the handshake (no req/rsp overlap).
//  reinit ignored outside IDLE. rst mid-transaction drops the transaction: no response, count kept 0.
//  ALU_LATENCY outside 1..15 or ALU_RST_CYCLES outside 1..255: elaboration error.
// TESTING
//  T1 reset: rst high 3 cycles then low, ALU_RST_CYCLES=4 -> alu_rst high exactly 4 cycles after
//   rst falls, req_ready=0 during INIT, then 1; rsp_valid=0, txn_count=0 throughout.
//  T2 single txn: A=3,B=-2,opcode=0,flags=0, ALU model out=1 after 1 edge -> rsp_valid at
//   accept+2 cycles, rsp_out=6'd1, rsp_opcode=0, txn_count=1 after handshake.
//  T3 backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, new req_valid not accepted;
//   rsp_ready=1 -> one handshake, IDLE next cycle.
//  T4 reinit collision: in IDLE drive reinit=1 and req_valid=1 same cycle -> no accept, alu_rst high
//   ALU_RST_CYCLES cycles, request accepted after return to IDLE.
//  T5 reset mid-op: assert rst during WAIT -> alu_rst=1, rsp_valid=0, alu pins 0 same cycle; no response.
//  T6 wrap: CNT_W=2, 5 back-to-back txns with ALU_LATENCY=3 -> txn_count 1,2,3,0,1; latency 4 each.

Source files
------------

// File: rtl/alu_stim_driver.sv
// alu_stim_driver: valid/ready initiator that applies one request to the ALU pins, waits a
// fixed ALU latency, captures out/leds and returns them; also sequences the ALU reset.
module alu_stim_driver #(
  parameter int ALU_LATENCY    = 1,
  parameter int ALU_RST_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reinit,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_A,
  input  logic [2:0]       req_B,
  input  logic [2:0]       req_opcode,
  input  logic [6:0]       req_flags,
  output logic             alu_rst,
  output logic [2:0]       alu_A,
  output logic [2:0]       alu_B,
  output logic [2:0]       alu_opcode,
  output logic [6:0]       alu_flags,
  input  logic [5:0]       alu_out,
  input  logic [15:0]      alu_leds,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_out,
  output logic [15:0]      rsp_leds,
  output logic [2:0]       rsp_opcode,
  output logic [CNT_W-1:0] txn_count
);

  generate
    if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
      $error("alu_stim_driver: ALU_LATENCY must be in 1..15");
    end
    if (ALU_RST_CYCLES < 1 || ALU_RST_CYCLES > 255) begin : g_bad_rst_cycles
      $error("alu_stim_driver: ALU_RST_CYCLES must be in 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] init_cnt;
  logic [3:0] wait_cnt;
  logic       init_done;
  logic       accept;
  logic       rsp_hs;

  // Handshake and reset outputs are pure decodes of the state, so async reset clears them at once.
  assign alu_rst   = (state == S_INIT);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign init_done = (init_cnt == 8'(ALU_RST_CYCLES - 1));
  assign accept    = (state == S_IDLE) && !reinit && req_valid;
  assign rsp_hs    = (state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (init_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (reinit)         state_nxt = S_INIT;
        else if (req_valid) state_nxt = S_WAIT;
      end
      S_WAIT: if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt <= 8'd0;
      wait_cnt <= 4'd0;
    end else begin
      if (state == S_INIT && !init_done) init_cnt <= init_cnt + 8'd1;
      else if (state == S_IDLE && reinit) init_cnt <= 8'd0;

      if (accept) wait_cnt <= 4'(ALU_LATENCY);
      else if (state == S_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // ALU pins hold the last accepted request until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_A      <= 3'd0;
      alu_B      <= 3'd0;
      alu_opcode <= 3'd0;
      alu_flags  <= 7'd0;
      rsp_out    <= 6'd0;
      rsp_leds   <= 16'd0;
      rsp_opcode <= 3'd0;
      txn_count  <= '0;
    end else begin
      if (accept) begin
        alu_A      <= req_A;
        alu_B      <= req_B;
        alu_opcode <= req_opcode;
        alu_flags  <= req_flags;
      end
      if (state == S_WAIT && wait_cnt == 4'd0) begin
        rsp_out    <= alu_out;
        rsp_leds   <= alu_leds;
        rsp_opcode <= alu_opcode;
      end
      if (rsp_hs) txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_stim_driver.sv
// tb_alu_stim_driver: drives alu_stim_driver against a behavioural ALU stand-in and checks
// responses, latency, backpressure, reinit, mid-transaction reset and txn_count wrap.
module tb_alu_stim_driver;

  localparam int LAT  = 1;
  localparam int RSTC = 4;
  localparam int CW   = 2;

  logic          clk;
  logic          rst;
  logic          reinit;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_A;
  logic [2:0]    req_B;
  logic [2:0]    req_opcode;
  logic [6:0]    req_flags;
  logic          alu_rst;
  logic [2:0]    alu_A;
  logic [2:0]    alu_B;
  logic [2:0]    alu_opcode;
  logic [6:0]    alu_flags;
  logic [5:0]    alu_out;
  logic [15:0]   alu_leds;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [5:0]    rsp_out;
  logic [15:0]   rsp_leds;
  logic [2:0]    rsp_opcode;
  logic [CW-1:0] txn_count;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;

  alu_stim_driver #(
    .ALU_LATENCY(LAT),
    .ALU_RST_CYCLES(RSTC),
    .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .reinit(reinit),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_A(req_A), .req_B(req_B), .req_opcode(req_opcode), .req_flags(req_flags),
    .alu_rst(alu_rst), .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode), .alu_flags(alu_flags),
    .alu_out(alu_out), .alu_leds(alu_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_opcode(rsp_opcode),
    .txn_count(txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: out is the sign-extended sum folded with opcode and flag bit 0, leds echo the pins.
  function automatic logic [5:0] refOut(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] op, input logic [6:0] fl);
    logic [5:0] sum;
    sum = {{3{a[2]}}, a} + {{3{b[2]}}, b};
    return sum ^ {op, 3'b000} ^ {5'b00000, fl[0]};
  endfunction

  function automatic logic [15:0] refLeds(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] op, input logic [6:0] fl);
    return {fl, op, a, b};
  endfunction

  logic [5:0]  pipeOut  [LAT];
  logic [15:0] pipeLeds [LAT];

  always_ff @(posedge clk) begin
    if (alu_rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipeOut[i]  <= 6'd0;
        pipeLeds[i] <= 16'd0;
      end
    end else begin
      pipeOut[0]  <= refOut(alu_A, alu_B, alu_opcode, alu_flags);
      pipeLeds[0] <= refLeds(alu_A, alu_B, alu_opcode, alu_flags);
      for (int i = 1; i < LAT; i++) begin
        pipeOut[i]  <= pipeOut[i-1];
        pipeLeds[i] <= pipeLeds[i-1];
      end
    end
  end

  assign alu_out  = pipeOut[LAT-1];
  assign alu_leds = pipeLeds[LAT-1];

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  op;
    logic [6:0]  fl;
    int          stall;
    logic [5:0]  wantOut;
    logic [15:0] wantLeds;
  } vecT;

  vecT vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  task automatic waitInit(input string name);
    int cnt;
    cnt = 0;
    while (alu_rst && cnt < 50) begin
      tick();
      cnt++;
      checkOutput({name, "_rsp_valid_low"}, rsp_valid, 0);
    end
    checkOutput({name, "_alu_rst_cycles"}, cnt, RSTC);
    checkOutput({name, "_req_ready_after"}, req_ready, 1);
  endtask

  // One full transaction; while stalled it also pushes a fresh request and reinit, both must be ignored.
  task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                               input logic [6:0] fl, input int stall, input bit early,
                               input logic [5:0] wantOut, input logic [15:0] wantLeds);
    int waitCnt;
    req_A = a; req_B = b; req_opcode = op; req_flags = fl;
    req_valid = 1'b1;
    waitCnt = 0;
    while (!req_ready && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkOutput("req_ready_before_accept", req_ready, 1);
    rsp_ready = early;
    tick();
    req_valid = 1'b0;
    checkOutput("req_ready_in_wait", req_ready, 0);
    checkOutput("alu_pins", {alu_A, alu_B, alu_opcode, alu_flags}, {a, b, op, fl});
    waitCnt = 0;
    while (!rsp_valid && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    checkOutput("accept_to_rsp_latency", waitCnt, LAT + 1);
    checkOutput("rsp_out", rsp_out, wantOut);
    checkOutput("rsp_leds", rsp_leds, wantLeds);
    checkOutput("rsp_opcode", rsp_opcode, op);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_A = ~a;
      reinit = 1'b1;
      tick();
      checkOutput("stall_rsp_valid", rsp_valid, 1);
      checkOutput("stall_rsp_stable", {rsp_out, rsp_leds}, {wantOut, wantLeds});
      checkOutput("stall_req_ready", req_ready, 0);
      checkOutput("stall_alu_rst", alu_rst, 0);
      checkOutput("stall_alu_A_held", alu_A, a);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    reinit = 1'b0;
    doneCount++;
    checkOutput("rsp_valid_after_hs", rsp_valid, 0);
    checkOutput("req_ready_after_hs", req_ready, 1);
    checkOutput("alu_rst_after_hs", alu_rst, 0);
    checkOutput("txn_count", txn_count, doneCount % (1 << CW));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2:0] ra, rb, rop;
    logic [6:0] rfl;
    int         rstall;
    bit         rearly;

    vecs[0] = '{a: 3'd3, b: 3'b110, op: 3'd0, fl: 7'h00, stall: 0, wantOut: 6'h01, wantLeds: 16'h001E};
    vecs[1] = '{a: 3'b100, b: 3'b100, op: 3'd0, fl: 7'h00, stall: 2, wantOut: 6'h38, wantLeds: 16'h0024};
    vecs[2] = '{a: 3'd3, b: 3'd3, op: 3'd5, fl: 7'h7F, stall: 0, wantOut: 6'h2F, wantLeds: 16'hFF5B};
    vecs[3] = '{a: 3'b111, b: 3'd1, op: 3'd2, fl: 7'h40, stall: 5, wantOut: 6'h10, wantLeds: 16'h80B9};

    rst = 1'b1; reinit = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_A = 3'd0; req_B = 3'd0; req_opcode = 3'd0; req_flags = 7'd0;

    $display("[TB] reset sequence");
    repeat (3) tick();
    checkOutput("reset_alu_rst", alu_rst, 1);
    checkOutput("reset_req_ready", req_ready, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_txn_count", txn_count, 0);
    checkOutput("reset_alu_pins", {alu_A, alu_B, alu_opcode, alu_flags}, 16'd0);
    checkOutput("reset_rsp_regs", {rsp_out, rsp_leds, rsp_opcode}, 25'd0);
    rst = 1'b0;
    waitInit("init");

    $display("[TB] table vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].fl, vecs[i].stall, 1'b0,
                    vecs[i].wantOut, vecs[i].wantLeds);
    end

    $display("[TB] reinit collides with req_valid");
    req_A = 3'd2; req_B = 3'd1; req_opcode = 3'd3; req_flags = 7'h15;
    req_valid = 1'b1;
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    checkOutput("reinit_alu_rst", alu_rst, 1);
    checkOutput("reinit_req_ready", req_ready, 0);
    checkOutput("reinit_no_accept", alu_A, vecs[3].a);
    waitInit("reinit");
    checkOutput("reinit_pins_untouched", {alu_A, alu_B}, {vecs[3].a, vecs[3].b});
    applyStimulus(3'd2, 3'd1, 3'd3, 7'h15, 0, 1'b1,
                  refOut(3'd2, 3'd1, 3'd3, 7'h15), refLeds(3'd2, 3'd1, 3'd3, 7'h15));

    $display("[TB] reset during WAIT");
    req_A = 3'd7; req_B = 3'd7; req_opcode = 3'd7; req_flags = 7'h7F;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checkOutput("midop_accepted", alu_A, 3'd7);
    rst = 1'b1;
    #1;
    doneCount = 0;
    checkOutput("midop_alu_rst", alu_rst, 1);
    checkOutput("midop_rsp_valid", rsp_valid, 0);
    checkOutput("midop_alu_pins", {alu_A, alu_B, alu_opcode, alu_flags}, 16'd0);
    checkOutput("midop_txn_count", txn_count, 0);
    tick();
    tick();
    rst = 1'b0;
    waitInit("midop");
    checkOutput("midop_no_response", rsp_valid, 0);

    $display("[TB] randomized back-to-back transactions");
    for (int n = 0; n < 10; n++) begin
      ra = 3'($urandom);
      rb = 3'($urandom);
      rop = 3'($urandom);
      rfl = 7'($urandom);
      rstall = $urandom_range(0, 2);
      rearly = (rstall == 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(ra, rb, rop, rfl, rstall, rearly, refOut(ra, rb, rop, rfl), refLeds(ra, rb, rop, rfl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
